// File: rtl/ssit_pkg.sv
// Shared store-set types: table geometry, SSID width and the training FSM states.
package ssit_pkg;

  localparam int SSIT_ENTRIES     = 1024;
  localparam int SSIT_INDEX_WIDTH = 10;
  localparam int STORE_SET_COUNT  = 64;
  localparam int SSID_WIDTH       = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } train_state_t;

endpackage

// File: rtl/ssit_train_fsm.sv
// Violation training sequencer: latches the load/store indices, reads both entries,
// then writes the merged or freshly allocated SSID back into both.
module ssit_train_fsm #(
  parameter int SSIT_INDEX_WIDTH = ssit_pkg::SSIT_INDEX_WIDTH,
  parameter int SSID_WIDTH       = ssit_pkg::SSID_WIDTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        clear,
  input  logic                        train_valid,
  output logic                        train_ready,
  input  logic [31:0]                 train_load_PC,
  input  logic [31:0]                 train_store_PC,
  output logic [SSIT_INDEX_WIDTH-1:0] load_idx,
  output logic [SSIT_INDEX_WIDTH-1:0] store_idx,
  input  logic                        load_entry_valid,
  input  logic [SSID_WIDTH-1:0]       load_entry_ssid,
  input  logic                        store_entry_valid,
  input  logic [SSID_WIDTH-1:0]       store_entry_ssid,
  output logic                        new_SSID_valid,
  input  logic [SSID_WIDTH-1:0]       new_SSID,
  output logic                        wr_en,
  output logic [SSID_WIDTH-1:0]       wr_ssid
);
  import ssit_pkg::*;

  train_state_t                state_reg, state_next;
  logic [SSIT_INDEX_WIDTH-1:0] load_idx_reg, store_idx_reg;
  logic                        load_valid_reg, store_valid_reg;
  logic [SSID_WIDTH-1:0]       load_ssid_reg, store_ssid_reg;
  logic                        accept;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{train_load_PC[31:SSIT_INDEX_WIDTH+2], train_load_PC[1:0],
                            train_store_PC[31:SSIT_INDEX_WIDTH+2], train_store_PC[1:0]};

  assign accept    = train_valid && train_ready;
  assign load_idx  = load_idx_reg;
  assign store_idx = store_idx_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      load_idx_reg  <= train_load_PC[SSIT_INDEX_WIDTH+1:2];
      store_idx_reg <= train_store_PC[SSIT_INDEX_WIDTH+1:2];
    end
    if (state_reg == READ) begin
      load_valid_reg  <= load_entry_valid;
      load_ssid_reg   <= load_entry_ssid;
      store_valid_reg <= store_entry_valid;
      store_ssid_reg  <= store_entry_ssid;
    end
  end

  // Same-index training reads one entry twice, so the rule collapses naturally to L = S.
  always_comb begin
    state_next     = state_reg;
    train_ready    = 1'b0;
    new_SSID_valid = 1'b0;
    wr_en          = 1'b0;
    wr_ssid        = '0;
    case (state_reg)
      IDLE: begin
        train_ready = !clear;
        if (train_valid && !clear) state_next = READ;
      end
      READ:  state_next = WRITE;
      WRITE: begin
        state_next = IDLE;
        if (nRST && !clear) begin
          wr_en = 1'b1;
          if (!load_valid_reg && !store_valid_reg) begin
            new_SSID_valid = 1'b1;
            wr_ssid        = new_SSID;
          end else if (load_valid_reg && store_valid_reg) begin
            wr_ssid = (load_ssid_reg < store_ssid_reg) ? load_ssid_reg : store_ssid_reg;
          end else begin
            wr_ssid = load_valid_reg ? load_ssid_reg : store_ssid_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

endmodule

// File: rtl/ssit.sv
// Store Set ID Table: PC-indexed {valid, SSID} array with a 1-cycle lookup port
// that touches the allocator on hits, plus a violation-training write path.
module ssit #(
  parameter int SSIT_ENTRIES     = ssit_pkg::SSIT_ENTRIES,
  parameter int SSIT_INDEX_WIDTH = $clog2(SSIT_ENTRIES),
  parameter int STORE_SET_COUNT  = ssit_pkg::STORE_SET_COUNT,
  parameter int SSID_WIDTH       = $clog2(STORE_SET_COUNT)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  clear,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_PC,
  output logic                  lookup_resp_valid,
  output logic                  lookup_resp_hit,
  output logic [SSID_WIDTH-1:0] lookup_resp_SSID,
  output logic                  touch_SSID_valid,
  output logic [SSID_WIDTH-1:0] touch_SSID,
  input  logic                  train_valid,
  output logic                  train_ready,
  input  logic [31:0]           train_load_PC,
  input  logic [31:0]           train_store_PC,
  output logic                  new_SSID_valid,
  input  logic [SSID_WIDTH-1:0] new_SSID
);

  logic [SSIT_ENTRIES-1:0]     valid_reg;
  logic [SSID_WIDTH-1:0]       ssid_reg [SSIT_ENTRIES];

  logic [SSIT_INDEX_WIDTH-1:0] lookup_idx;
  logic                        lookup_hit;
  logic                        resp_valid_reg, resp_hit_reg;
  logic [SSID_WIDTH-1:0]       resp_ssid_reg;

  logic [SSIT_INDEX_WIDTH-1:0] load_idx, store_idx;
  logic                        wr_en;
  logic [SSID_WIDTH-1:0]       wr_ssid;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_PC[31:SSIT_INDEX_WIDTH+2], lookup_PC[1:0]};

  assign lookup_idx = lookup_PC[SSIT_INDEX_WIDTH+1:2];
  assign lookup_hit = lookup_valid && valid_reg[lookup_idx];

  ssit_train_fsm #(
    .SSIT_INDEX_WIDTH (SSIT_INDEX_WIDTH),
    .SSID_WIDTH       (SSID_WIDTH)
  ) u_train_fsm (
    .CLK               (CLK),
    .nRST              (nRST),
    .clear             (clear),
    .train_valid       (train_valid),
    .train_ready       (train_ready),
    .train_load_PC     (train_load_PC),
    .train_store_PC    (train_store_PC),
    .load_idx          (load_idx),
    .store_idx         (store_idx),
    .load_entry_valid  (valid_reg[load_idx]),
    .load_entry_ssid   (ssid_reg[load_idx]),
    .store_entry_valid (valid_reg[store_idx]),
    .store_entry_ssid  (ssid_reg[store_idx]),
    .new_SSID_valid    (new_SSID_valid),
    .new_SSID          (new_SSID),
    .wr_en             (wr_en),
    .wr_ssid           (wr_ssid)
  );

  // Lookups register the pre-write table contents, so a same-cycle write stays invisible.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_ssid_reg  <= '0;
    end else begin
      resp_valid_reg <= lookup_valid;
      resp_hit_reg   <= lookup_hit;
      resp_ssid_reg  <= lookup_hit ? ssid_reg[lookup_idx] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST || clear) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[load_idx]  <= 1'b1;
      valid_reg[store_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      ssid_reg[load_idx]  <= wr_ssid;
      ssid_reg[store_idx] <= wr_ssid;
    end
  end

  assign lookup_resp_valid = resp_valid_reg;
  assign lookup_resp_hit   = resp_hit_reg;
  assign lookup_resp_SSID  = resp_ssid_reg;
  assign touch_SSID_valid  = resp_hit_reg;
  assign touch_SSID        = resp_ssid_reg;

endmodule

// File: tb/tb_ssit.sv
// Randomized scoreboard bench for ssit against a set-level store-set model.
module tb_ssit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        clear = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_PC = '0;
  logic        lookup_resp_valid, lookup_resp_hit;
  logic [5:0]  lookup_resp_SSID;
  logic        touch_SSID_valid;
  logic [5:0]  touch_SSID;
  logic        train_valid = 1'b0;
  logic        train_ready;
  logic [31:0] train_load_PC = '0;
  logic [31:0] train_store_PC = '0;
  logic        new_SSID_valid;
  logic [5:0]  new_SSID = '0;

  ssit dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .clear             (clear),
    .lookup_valid      (lookup_valid),
    .lookup_PC         (lookup_PC),
    .lookup_resp_valid (lookup_resp_valid),
    .lookup_resp_hit   (lookup_resp_hit),
    .lookup_resp_SSID  (lookup_resp_SSID),
    .touch_SSID_valid  (touch_SSID_valid),
    .touch_SSID        (touch_SSID),
    .train_valid       (train_valid),
    .train_ready       (train_ready),
    .train_load_PC     (train_load_PC),
    .train_store_PC    (train_store_PC),
    .new_SSID_valid    (new_SSID_valid),
    .new_SSID          (new_SSID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int hit;
    int ssid;
  } resp_t;

  resp_t rq[$];
  int    nq[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model: which store set each table slot belongs to.
  bit          m_valid [1024];
  int          m_ssid  [1024];
  bit          busy = 0;
  int          apply_cyc = 0;
  logic [31:0] p_load, p_store;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 1024);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] idx;
    idx = ($urandom_range(0, 19) == 0) ? 32'd1023 : 32'($urandom_range(0, 15));
    return ($urandom & 32'hFFFF_F003) | (idx << 2);
  endfunction

  task automatic step(input bit lv, input logic [31:0] lpc, input bit tv,
                      input logic [31:0] tl, input logic [31:0] ts,
                      input bit clr, input logic [5:0] nsid);
    int    c, li, si, w;
    bit    exp_ready;
    resp_t e;
    @(negedge CLK);
    nRST = 1'b1; lookup_valid = lv; lookup_PC = lpc; train_valid = tv;
    train_load_PC = tl; train_store_PC = ts; clear = clr; new_SSID = nsid;
    #1;
    c = cyc;
    exp_ready = !busy && !clr;
    check("train_ready", int'(train_ready), int'(exp_ready));
    if (lv) begin
      li = midx(lpc);
      e.cyc = c + 1;
      e.hit = int'(m_valid[li]);
      e.ssid = m_valid[li] ? m_ssid[li] : 0;
      rq.push_back(e);
    end
    if (busy && c == apply_cyc) begin
      if (!clr) begin
        li = midx(p_load);
        si = midx(p_store);
        if (!m_valid[li] && !m_valid[si]) begin
          w = int'(nsid);
          nq.push_back(c);
        end else if (m_valid[li] && m_valid[si]) begin
          w = (m_ssid[li] < m_ssid[si]) ? m_ssid[li] : m_ssid[si];
        end else begin
          w = m_valid[li] ? m_ssid[li] : m_ssid[si];
        end
        m_valid[li] = 1; m_ssid[li] = w;
        m_valid[si] = 1; m_ssid[si] = w;
      end
      busy = 0;
    end
    if (clr) begin
      foreach (m_valid[k]) m_valid[k] = 0;
      busy = 0;
    end
    if (tv && exp_ready) begin
      busy = 1;
      apply_cyc = c + 2;
      p_load = tl;
      p_store = ts;
    end
  endtask

  task automatic look(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 6'd0);
  endtask

  // train_valid stays high through READ/WRITE to show it is accepted only once.
  task automatic train(input logic [31:0] l, input logic [31:0] s, input logic [5:0] n);
    repeat (3) step(0, 0, 1, l, s, 0, n);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; lookup_valid = 0; train_valid = 0; clear = 0;
    #1;
    check("nsv_during_reset", int'(new_SSID_valid), 0);
    foreach (m_valid[k]) m_valid[k] = 0;
    busy = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response or an allocation.
  initial begin
    forever begin
      resp_t e;
      @(negedge CLK);
      #2;
      if (lookup_resp_valid) begin
        if (rq.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = rq.pop_front();
          check("resp_latency", cyc, e.cyc);
          check("resp_hit", int'(lookup_resp_hit), e.hit);
          check("resp_ssid", int'(lookup_resp_SSID), e.ssid);
          check("touch_valid", int'(touch_SSID_valid), e.hit);
          if (e.hit != 0) check("touch_ssid", int'(touch_SSID), e.ssid);
          $display("lookup cyc=%0d hit=%0d ssid=%0d", cyc, lookup_resp_hit, lookup_resp_SSID);
        end
      end else if (touch_SSID_valid) begin
        check("touch_without_resp", 1, 0);
      end
      if (new_SSID_valid) begin
        if (nq.size() == 0) check("nsv_unexpected", 1, 0);
        else check("nsv_cycle", cyc, nq.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    #2;
    check("rst_resp_valid", int'(lookup_resp_valid), 0);
    check("rst_resp_hit", int'(lookup_resp_hit), 0);
    check("rst_resp_ssid", int'(lookup_resp_SSID), 0);
    check("rst_touch_valid", int'(touch_SSID_valid), 0);
    check("rst_touch_ssid", int'(touch_SSID), 0);
    check("rst_new_ssid_valid", int'(new_SSID_valid), 0);
    check("rst_train_ready", int'(train_ready), 1);

    look(32'h100);
    train(32'h100, 32'h200, 6'd5);
    look(32'h100);
    look(32'h200);
    train(32'h300, 32'h200, 6'd12);
    look(32'h300);
    step(0, 0, 0, 0, 0, 1, 6'd0);
    train(32'h100, 32'h100, 6'd9);
    train(32'h400, 32'h400, 6'd3);
    train(32'h100, 32'h400, 6'd20);
    look(32'h100);
    look(32'h400);
    step(0, 0, 1, 32'h600, 32'h700, 0, 6'd1);
    step(0, 0, 0, 0, 0, 1, 6'd1);
    look(32'h600);
    look(32'h700);
    look(32'h100);
    train(32'h500, 32'h500, 6'd7);
    look(32'h500);
    step(0, 0, 1, 32'h800, 32'h900, 0, 6'd2);
    step(0, 0, 0, 0, 0, 0, 6'd2);
    step(1, 32'h500, 0, 0, 0, 1, 6'd2);
    look(32'h800);
    look(32'h500);
    train(32'hA00, 32'hB00, 6'd4);
    step(1, 32'hA00, 1, 32'hC00, 32'hD00, 0, 6'd8);
    step(0, 0, 0, 0, 0, 0, 6'd8);
    do_reset();
    look(32'hC00);
    look(32'hA00);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 1) != 0,
           rand_pc(), rand_pc(), $urandom_range(0, 63) == 0, 6'($urandom));
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 6'd0);

    @(negedge CLK);
    #3;
    check("resp_queue_drained", rq.size(), 0);
    check("nsv_queue_drained", nq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssit.md
# ssit

Store Set ID Table: PC-indexed table mapping load and store PCs to store set IDs (SSIDs) for memory dependence prediction. It sits in the load/store dispatch path.
- Lookups report whether an instruction belongs to a store set.
- On a lookup hit, it sends a touch to the SSID allocator (sst) through `touch_SSID_valid`/`touch_SSID`.
- On a memory-ordering violation, it trains by pairing the load and store into one set, taking a fresh SSID from sst through `new_SSID_valid`/`new_SSID` when needed.

## Interface
Parameters:
- SSIT_ENTRIES, 1024, table entries (power of 2)
- SSIT_INDEX_WIDTH, 10, log2(SSIT_ENTRIES)
- STORE_SET_COUNT, 64, number of SSIDs (shared with sst)
- SSID_WIDTH, 6, log2(STORE_SET_COUNT)

Ports:
- CLK  in  1  clock; single clock domain
- nRST  in  1  reset; synchronous, active-low
- clear  in  1  pulse: invalidate whole table
- lookup_valid  in  1  lookup request, always accepted
- lookup_PC  in  32  instruction PC
- lookup_resp_valid  out  1  response strobe
- lookup_resp_hit  out  1  entry valid
- lookup_resp_SSID  out  SSID_WIDTH  entry SSID (0 on miss)
- touch_SSID_valid  out  1  touch strobe to sst
- touch_SSID  out  SSID_WIDTH  SSID being touched
- train_valid  in  1  violation training request
- train_ready  out  1  training accepted when valid&ready
- train_load_PC  in  32  violating load PC
- train_store_PC  in  32  conflicting store PC
- new_SSID_valid  out  1  consume sst's current free SSID this cycle
- new_SSID  in  SSID_WIDTH  SSID offered by sst, valid every cycle

## Operation
- Index function: PC[SSIT_INDEX_WIDTH+1:2]. Each entry holds {valid, SSID}.
- Lookup:
  - The lookup sampled at cycle T responds at T+1 with lookup_resp_valid=1.
  - hit = entry valid; SSID = entry SSID on a hit, 0 on a miss.
  - On a hit, touch_SSID_valid=1 and touch_SSID=SSID in the same cycle as the response.
- Training FSM, three states:
  - IDLE: train_ready=1. Accept a request → latch both indices → READ.
  - READ: read the load entry L and store entry S into registers → WRITE.
  - WRITE: apply the rule below, then → IDLE.
- WRITE rule (Chrysos-Emer):
  - Neither valid: assert new_SSID_valid; write new_SSID into both L and S.
  - Exactly one valid: copy its SSID into the other entry.
  - Both valid: write min(L.SSID, S.SSID) into both entries (merge).
  - Same index for load and store: one entry is written, using the same rule with L = S.
- clear: all valid bits are 0 from the next cycle. An in-flight training is aborted (FSM → IDLE, nothing written).
- clear and train_valid in the same cycle: the training is not accepted; train_ready is 0 during the clear cycle.
- Reset mid-training: FSM → IDLE, no write, new_SSID_valid=0.

## Timing
- Reset values:
  - Outputs: lookup_resp_valid, lookup_resp_hit, lookup_resp_SSID, touch_SSID_valid, touch_SSID and new_SSID_valid are 0.
  - train_ready is 1 (IDLE).
  - Table: all entries invalid.
- Lookup latency is 1 cycle, with a throughput of one lookup per cycle.
- A lookup sees the table state as of the start of its sample cycle. A write in that same cycle is not visible; it is visible to lookups sampled the next cycle.
- Training sequence:
  - Accepted at T; READ at T+1; WRITE at T+2.
  - The table update is visible to lookups sampled at T+3.
  - train_ready returns to 1 at T+3, so at most one training per 3 cycles.
- new_SSID_valid is a one-cycle pulse, only in WRITE, and only in the neither-valid case. new_SSID is sampled in that cycle.
- Training never drives touch. The touch port carries lookup hits only, so there is no arbitration.

## Structure
- Shared core types package holds STORE_SET_COUNT, SSID_WIDTH, SSIT_ENTRIES, SSIT_INDEX_WIDTH and the training-state enum (IDLE/READ/WRITE).
- Table storage is a flop array with one lookup read port, one training read port (2 indices) and one 2-entry write port.
- Natural sub-module: ssit_train_fsm (FSM plus the merge/allocate decision). The table array stays in ssit.
- A wrapper pairs ssit with sst for integration benches.

## Test plan
- Reset, then lookup PC=0x100 → at T+1: resp_valid=1, hit=0, SSID=0, touch_SSID_valid=0.
- Train load=0x100, store=0x200, both invalid, new_SSID=5 → new_SSID_valid pulses at T+2 only. Lookups of 0x100 and 0x200 sampled at T+3 → hit=1, SSID=5, touch_SSID=5.
- Only 0x200 valid (SSID 5); train load=0x300, store=0x200 → 0x300 gets SSID 5; no new_SSID_valid.
- 0x100=SSID 9 and 0x400=SSID 3; train the pair → both read SSID 3.
- Training in progress at READ, then clear pulse → no write occurs; all lookups miss; train_ready=1 next cycle.
- Load PC equals store PC (0x500), both invalid, new_SSID=7 → single entry=7. Also: train_valid held high during READ/WRITE is not accepted twice.
